// File: rtl/ls_program_loader.sv
// ls_program_loader: streams bytes into 128-bit quadwords and writes them to
// the local store at consecutive quadword addresses starting at base_address.
// Optional feature: define LOADER_CHECKSUM_EN to enable the running 16-bit
// byte checksum on checksum_out; otherwise checksum_out is tied to zero.
//
// Handshake: a byte transfers on a rising clock edge where load_valid and
// load_ready are both high; load_ready depends only on the FSM state (high in
// FILL), never on load_valid, so the source may hold load_valid high freely.
//
// Bit numbering is big-endian: bit 0 is the most significant bit of a bus,
// and the k-th byte of a quadword sits in LS_data_input[8k:8k+7].
module ls_program_loader (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [0:14]   base_address,
  input  logic [0:15]   byte_count,
  input  logic          load_valid,
  input  logic [0:7]    load_data,
  output logic          load_ready,
  output logic          LS_wrt_en,
  output logic [0:14]   LS_address,
  output logic [0:127]  LS_data_input,
  output logic          busy,
  output logic          done,
  output logic [0:15]   checksum_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [10:0]   qw_q, qw_d;          // quadword index (address bits above the 16-byte offset)
  logic [15:0]   remaining_q, remaining_d;
  logic [3:0]    idx_q, idx_d;        // byte slot within the current quadword
  logic [0:127]  buf_q, buf_d;

  logic          start_ok;
  logic          accept;
  logic          base_unused;

  // The low nibble of the base is ignored: loads always start on a quadword.
  assign base_unused = ^base_address[11:14];

  assign start_ok = (state_q == S_IDLE) && start;
  assign accept   = (state_q == S_FILL) && load_valid;

  // State register and datapath flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      qw_q        <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      qw_q        <= qw_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
    end
  end

  // Next-state logic: assemble bytes in FILL, emit one write per quadword.
  always_comb begin
    state_d     = state_q;
    qw_d        = qw_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (byte_count != 16'd0) begin
            qw_d        = base_address[0:10];
            remaining_d = byte_count;
            idx_d       = 4'd0;
            buf_d       = '0;
            state_d     = S_FILL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FILL: begin
        if (load_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = load_data;
          idx_d       = idx_q + 4'd1;
          remaining_d = remaining_q - 16'd1;
          if ((idx_q == 4'd15) || (remaining_q == 16'd1)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // 11-bit index wraps naturally: 0x7FF0 advances to 0x0000.
        qw_d    = qw_q + 11'd1;
        idx_d   = 4'd0;
        buf_d   = '0;
        state_d = (remaining_q == 16'd0) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign load_ready    = (state_q == S_FILL);
  assign LS_wrt_en     = (state_q == S_WRITE);
  assign LS_address    = {qw_q, 4'b0000};
  assign LS_data_input = buf_q;
  assign busy          = (state_q == S_FILL) || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Checksum accumulator: cleared on an accepted start, summed per byte.
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + {8'h00, load_data};
    end
  end

  // Checksum register.
  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_out = csum_q;
`else
  logic start_ok_unused;
  logic accept_unused;
  assign start_ok_unused = start_ok;
  assign accept_unused   = accept;
  assign checksum_out    = '0;
`endif

endmodule

// File: tb/tb_ls_program_loader.sv
// Testbench for ls_program_loader: directed load scenarios with a write
// scoreboard (address/data queues filled from a byte-level model).
module tb_ls_program_loader;

  logic          clock;
  logic          reset;
  logic          start;
  logic [0:14]   base_address;
  logic [0:15]   byte_count;
  logic          load_valid;
  logic [0:7]    load_data;
  logic          load_ready;
  logic          LS_wrt_en;
  logic [0:14]   LS_address;
  logic [0:127]  LS_data_input;
  logic          busy;
  logic          done;
  logic [0:15]   checksum_out;

  int checks   = 0;
  int failures = 0;

  logic [14:0]  exp_addr_q[$];
  logic [127:0] exp_data_q[$];
  logic [7:0]   bytes_q[$];
  logic [15:0]  exp_csum;

  ls_program_loader dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_address  (base_address),
    .byte_count    (byte_count),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .LS_wrt_en     (LS_wrt_en),
    .LS_address    (LS_address),
    .LS_data_input (LS_data_input),
    .busy          (busy),
    .done          (done),
    .checksum_out  (checksum_out)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset === 1'b0 && LS_wrt_en === 1'b1) begin
      check("write_ready_low", load_ready, 0);
      checks++;
      assert (exp_addr_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=%0h expected=no write", LS_address);
      end
      if (exp_addr_q.size() > 0) begin
        check("write_addr", LS_address, exp_addr_q.pop_front());
        check("write_data", LS_data_input, exp_data_q.pop_front());
      end
    end
  end

  // Reference model: split bytes_q into quadword writes and sum the bytes.
  task automatic build_expected(input logic [14:0] base, input int count);
    logic [14:0]  a;
    logic [127:0] d;
    int           k;
    a = base & 15'h7FF0;
    d = '0;
    k = 0;
    exp_csum = '0;
    for (int i = 0; i < count; i++) begin
      d[127 - 8*k -: 8] = bytes_q[i];
      exp_csum = exp_csum + {8'h00, bytes_q[i]};
      k++;
      if (k == 16 || i == count - 1) begin
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        a = (a + 15'd16) & 15'h7FF0;
        d = '0;
        k = 0;
      end
    end
  endtask

  // Present one byte and hold it until the loader takes it (bounded).
  task automatic push_byte(input logic [7:0] b);
    logic rdy;
    bit   ok;
    load_valid = 1'b1;
    load_data  = b;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      rdy = load_ready;
      tick();
      if (rdy === 1'b1) ok = 1;
    end
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL byte_accept_timeout observed=not accepted expected=accepted byte %0h", b);
    end
  endtask

  task automatic pulse_start(input logic [14:0] base, input int count);
    start        = 1'b1;
    base_address = base;
    byte_count   = count[15:0];
    tick();
    start = 1'b0;
  endtask

  // Full load of bytes_q with optional gaps and a stray start mid-load.
  task automatic run_load(input logic [14:0] base, input int count, input bit gap, input bit repulse);
    build_expected(base, count);
    pulse_start(base, count);
    check("busy_rise", busy, 1);
    check("ready_in_fill", load_ready, 1);
    for (int i = 0; i < count; i++) begin
      push_byte(bytes_q[i]);
      if (gap && i != count - 1) begin
        load_valid = 1'b0;
        if (repulse && i == 5) begin
          start        = 1'b1;
          base_address = 15'h0100;
          byte_count   = 16'd3;
        end
        tick();
        start = 1'b0;
      end
    end
    load_valid = 1'b0;
    check("write_latency", LS_wrt_en, 1);
    tick();
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("no_write_in_done", LS_wrt_en, 0);
    check("ready_low_done", load_ready, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum_out, exp_csum);
`else
    check("checksum_off", checksum_out, 0);
`endif
    check("writes_drained", exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_load_ready", load_ready, 0);
    check("rst_wrt_en", LS_wrt_en, 0);
    check("rst_address", LS_address, 0);
    check("rst_data", LS_data_input, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum_out, 0);
  endtask

  initial begin
    bit seen_done;
    bit seen_busy;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    byte_count   = '0;
    load_valid   = 1'b0;
    load_data    = '0;
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();
    check("idle_ready_low", load_ready, 0);

    // 16 bytes back-to-back at base 0.
    bytes_q = {};
    for (int i = 0; i < 16; i++) bytes_q.push_back(8'(i));
    run_load(15'h0000, 16, 0, 0);

    // Unaligned base, 20 bytes: full quadword then partial zero-padded one.
    bytes_q = {};
    for (int i = 1; i <= 20; i++) bytes_q.push_back(8'(i));
    run_load(15'h0013, 20, 0, 0);

    // Address wrap at the top of the local store.
    bytes_q = {};
    for (int i = 0; i < 32; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    run_load(15'h7FF0, 32, 0, 0);

    // Zero-length load.
    pulse_start(15'h0040, 0);
    seen_done = 0;
    seen_busy = 0;
    for (int t = 0; t < 2 && !seen_done; t++) begin
      if (done === 1'b1) seen_done = 1;
      if (busy !== 1'b0) seen_busy = 1;
      if (!seen_done) tick();
    end
    check("zero_done", seen_done, 1);
    check("zero_busy", seen_busy, 0);
    tick();
    check("zero_done_cleared", done, 0);
    check("zero_checksum", checksum_out, 0);

    // Stalled stream with a stray start in the middle.
    bytes_q = {};
    for (int i = 0; i < 16; i++) bytes_q.push_back(8'(i));
    run_load(15'h0000, 16, 1, 1);

    // Random base and length spanning several quadwords with gaps.
    bytes_q = {};
    begin
      int n;
      logic [14:0] b;
      n = $urandom_range(17, 40);
      b = 15'($urandom_range(0, 32767));
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
      run_load(b, n, 1, 0);
    end

    // Reset in the middle of a quadword: nothing written.
    bytes_q = {};
    pulse_start(15'h0300, 16);
    for (int i = 0; i < 7; i++) push_byte(8'(8'hA0 + i));
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();
    check("post_reset_idle", busy, 0);

    // All-ones bytes: checksum 0x0FF0 when enabled.
    bytes_q = {};
    for (int i = 0; i < 16; i++) bytes_q.push_back(8'hFF);
    run_load(15'h0200, 16, 0, 0);

    repeat (3) tick();
    check("final_queue_empty", exp_addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
